// File: rtl/fifo_rd_drain_if.sv
// fifo_rd_drain_if: FIFO read-side flags/data plus downstream valid/ready bundle for fifo_rd_drain.
interface fifo_rd_drain_if #(
    parameter int DATA_WIDTH = 4
);
    logic                  empty_in;
    logic                  almost_empty_in;
    logic [DATA_WIDTH-1:0] fifo_data_in;
    logic                  rd_en_out;
    logic                  burst_en_in;
    logic                  ready_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  busy_out;
    logic                  burst_short_out;
    logic [7:0]            pop_count_out;
    modport slave (
        input  empty_in, almost_empty_in, fifo_data_in, burst_en_in, ready_in,
        output rd_en_out, data_out, valid_out, busy_out, burst_short_out, pop_count_out
    );
    modport master (
        output empty_in, almost_empty_in, fifo_data_in, burst_en_in, ready_in,
        input  rd_en_out, data_out, valid_out, busy_out, burst_short_out, pop_count_out
    );
endinterface

// File: rtl/fifo_rd_drain.sv
// fifo_rd_drain: async-FIFO read controller with pop FSM, 2-entry skid buffer and stream/burst modes.
// Optional pop counter built when FIFO_RD_POP_COUNT_EN is defined.
module fifo_rd_drain #(
    parameter int DATA_WIDTH = 4,
    parameter int BURST_LEN  = 4
) (
    input logic           rd_clk_in,
    input logic           rst_n_rd_in,
    fifo_rd_drain_if.slave bus
);
    typedef enum logic [1:0] {IDLE, STREAM, BURST, DRAIN} state_t;
    state_t                state_q;
    logic [7:0]            cnt_q;
    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q, short_q;
    logic [DATA_WIDTH-1:0] e0_q, e1_q, e0_d, e1_d;
    logic                  pop_state, credit_ok, rd_en, xfer;
    assign xfer      = bus.valid_out & bus.ready_in;
    assign pop_state = state_q == STREAM ? !bus.burst_en_in : state_q == BURST;
    // Words already captured or still in flight must fit in two entries after this cycle's hand-off.
    assign credit_ok = ({1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, xfer}) < 3'd2;
    assign rd_en     = pop_state & !bus.empty_in & credit_ok;
    assign bus.rd_en_out       = rd_en;
    assign bus.data_out        = e0_q;
    assign bus.valid_out       = occ_q != 2'd0;
    assign bus.busy_out        = state_q != IDLE;
    assign bus.burst_short_out = short_q;
    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        occ_d = occ_q;
        if (xfer) begin
            e0_d  = e1_q;
            occ_d = occ_q - 2'd1;
        end
        if (inflight_q) begin
            e0_d  = occ_d == 2'd0 ? bus.fifo_data_in : e0_d;
            e1_d  = occ_d == 2'd0 ? e1_d : bus.fifo_data_in;
            occ_d = occ_d + 2'd1;
        end
    end
    always_ff @(posedge rd_clk_in or negedge rst_n_rd_in) begin
        if (!rst_n_rd_in) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            short_q    <= 1'b0;
            e0_q       <= '0;
            e1_q       <= '0;
        end else begin
            occ_q      <= occ_d;
            e0_q       <= e0_d;
            e1_q       <= e1_d;
            inflight_q <= rd_en;
            short_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!bus.burst_en_in && !bus.empty_in) begin
                        state_q <= STREAM;
                    end else if (bus.burst_en_in && !bus.almost_empty_in) begin
                        state_q <= BURST;
                        cnt_q   <= 8'(BURST_LEN);
                    end
                end
                STREAM: if (bus.burst_en_in) state_q <= DRAIN;
                BURST: begin
                    if (rd_en) begin
                        cnt_q   <= cnt_q - 8'd1;
                        state_q <= cnt_q == 8'd1 ? DRAIN : BURST;
                    end else if (bus.empty_in) begin
                        cnt_q   <= 8'd0;
                        short_q <= 1'b1;
                        state_q <= DRAIN;
                    end
                end
                DRAIN: if (!inflight_q && occ_q == 2'd0) state_q <= IDLE;
            endcase
        end
    end
`ifdef FIFO_RD_POP_COUNT_EN
    logic [7:0] pop_cnt_q;
    always_ff @(posedge rd_clk_in or negedge rst_n_rd_in) begin
        if (!rst_n_rd_in) pop_cnt_q <= 8'd0;
        else if (rd_en) pop_cnt_q <= pop_cnt_q + 8'd1;
    end
    assign bus.pop_count_out = pop_cnt_q;
`else
    assign bus.pop_count_out = 8'd0;
`endif
endmodule

// File: tb/tb_fifo_rd_drain.sv
// tb_fifo_rd_drain: queue-based FIFO model feeds the DUT; a monitor scores every hand-off against the pop order.
module tb_fifo_rd_drain;
    localparam int DW = 4;
    localparam int BL = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;
    fifo_rd_drain_if #(.DATA_WIDTH(DW)) bus();
    fifo_rd_drain #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .rd_clk_in  (clk),
        .rst_n_rd_in(rst_n),
        .bus        (bus)
    );
    int checks = 0, errors = 0, cyc = 0;
    int pops = 0, xfers = 0, shorts = 0;
    int ready_pct = 100, wr_pct = 0, wr_left = 0, ae_th = 1;
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    int pop_cyc[$];
    int xfer_cyc[$];
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask
    task automatic drive_flags();
        bus.empty_in        = fifo_q.size() == 0;
        bus.almost_empty_in = fifo_q.size() < ae_th;
    endtask
    task automatic check_reset();
        check("reset_outputs", int'({bus.rd_en_out, bus.valid_out, bus.busy_out,
              bus.burst_short_out, bus.pop_count_out, bus.data_out}), 0);
    endtask
    // Observe the pop mid-cycle, then present next cycle's inputs just after the edge.
    task automatic cycle();
        logic [DW-1:0] w;
        logic popped;
        @(negedge clk);
        #1;
        w = DW'($urandom);
        popped = rst_n && bus.rd_en_out && fifo_q.size() > 0;
        if (popped) begin
            w = fifo_q.pop_front();
            exp_q.push_back(w);
            pops++;
            pop_cyc.push_back(cyc);
        end
        if (fifo_q.size() < 8 && (wr_left > 0 || $urandom_range(0, 99) < wr_pct)) begin
            fifo_q.push_back(DW'($urandom));
            if (wr_left > 0) wr_left--;
        end
        @(posedge clk);
        #1;
        bus.fifo_data_in = popped ? w : DW'($urandom);
        bus.ready_in     = $urandom_range(0, 99) < ready_pct;
        drive_flags();
    endtask
    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (bus.busy_out && n < 200);
        check({name, "_idle"}, int'(bus.busy_out), 0);
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        pops = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            check_reset();
        end
        rst_n = 1'b1;
    endtask
    logic          held = 1'b0;
    logic [DW-1:0] held_d;
    always @(negedge clk) begin
        logic [DW-1:0] e;
        logic          x;
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            x = bus.valid_out && bus.ready_in;
            if (bus.rd_en_out) begin
                check("pop_when_empty", int'(bus.empty_in), 0);
                check("credit", int'((exp_q.size() - int'(x)) < 2), 1);
            end
            if (held) check("hold_stable", int'({bus.valid_out, bus.data_out}), int'({1'b1, held_d}));
            if (x) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("data_order", int'(bus.data_out), int'(e));
                end
                xfers++;
                xfer_cyc.push_back(cyc);
            end
            held   = bus.valid_out && !bus.ready_in;
            held_d = bus.data_out;
            if (bus.burst_short_out) shorts++;
        end
    end
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
    initial begin
        int p0, x0, s0, n, exp_cnt;
        logic [DW-1:0] first;
        bus.ready_in     = 1'b1;
        bus.burst_en_in  = 1'b0;
        bus.fifo_data_in = '0;
        for (int i = 0; i < 8; i++) fifo_q.push_back(DW'(i + 1));
        drive_flags();
        #2 rst_n = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            check_reset();
        end
        fifo_q.delete();
        bus.burst_en_in = 1'b1;
        drive_flags();
        rst_n = 1'b1;
        repeat (2) cycle();
        // Stream of 5,6,7,8 at full throughput.
        ae_th = 100;
        fifo_q = '{4'd5, 4'd6, 4'd7, 4'd8};
        drive_flags();
        cycle();
        pop_cyc.delete();
        xfer_cyc.delete();
        bus.burst_en_in = 1'b0;
        repeat (12) cycle();
        check("t2_pops", pop_cyc.size(), 4);
        check("t2_xfers", xfer_cyc.size(), 4);
        for (int i = 1; i < 4 && i < pop_cyc.size(); i++) check("t2_pop_consec", pop_cyc[i] - pop_cyc[i-1], 1);
        for (int i = 0; i < 4 && i < pop_cyc.size() && i < xfer_cyc.size(); i++)
            check("t2_latency", xfer_cyc[i] - pop_cyc[i], 2);
        bus.burst_en_in = 1'b1;
        wait_idle("t2");
        // Backpressure: two words in flight, head held.
        for (int i = 0; i < 6; i++) fifo_q.push_back(DW'($urandom));
        first = fifo_q[0];
        drive_flags();
        p0 = pops;
        x0 = xfers;
        ready_pct = 0;
        bus.ready_in = 1'b0;
        bus.burst_en_in = 1'b0;
        repeat (10) cycle();
        check("t3_pops_stalled", pops - p0, 2);
        check("t3_head_held", int'({bus.valid_out, bus.data_out}), int'({1'b1, first}));
        ready_pct = 100;
        n = 0;
        do begin
            cycle();
            n++;
        end while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < 40);
        check("t3_delivered", xfers - x0, 6);
        bus.burst_en_in = 1'b1;
        wait_idle("t3");
        // Full burst, then waits for almost-empty to clear.
        ae_th = 3;
        ready_pct = 70;
        p0 = pops;
        s0 = shorts;
        for (int i = 0; i < 6; i++) fifo_q.push_back(DW'($urandom));
        drive_flags();
        cycle();
        wait_idle("t4a");
        check("t4_burst_pops", pops - p0, BL);
        repeat (10) cycle();
        check("t4_no_rearm", pops - p0, BL);
        fifo_q.push_back(DW'($urandom));
        fifo_q.push_back(DW'($urandom));
        drive_flags();
        cycle();
        wait_idle("t4b");
        check("t4_second_burst", pops - p0, 2 * BL);
        check("t4_no_short", shorts - s0, 0);
        // Short burst: only two words available.
        ae_th = 1;
        ready_pct = 50;
        p0 = pops;
        s0 = shorts;
        fifo_q.push_back(DW'($urandom));
        fifo_q.push_back(DW'($urandom));
        drive_flags();
        cycle();
        wait_idle("t5");
        check("t5_pops", pops - p0, 2);
        check("t5_short_pulse", shorts - s0, 1);
        check("t5_drained", int'({exp_q.size() == 0, bus.valid_out}), int'({1'b1, 1'b0}));
        // Randomised mix with a reset in the middle.
        ae_th = 3;
        wr_pct = 50;
        ready_pct = 60;
        bus.burst_en_in = 1'b0;
        for (int i = 0; i < 300; i++) begin
            cycle();
            if ($urandom_range(0, 15) == 0) bus.burst_en_in = !bus.burst_en_in;
            if (i == 150) do_reset();
        end
        wr_pct = 0;
        ready_pct = 100;
        bus.burst_en_in = 1'b0;
        n = 0;
        do begin
            cycle();
            n++;
        end while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < 200);
        check("rand_drained", int'(exp_q.size() + fifo_q.size()), 0);
        bus.burst_en_in = 1'b1;
        wait_idle("rand");
        // 260 pops after reset for the pop counter.
        do_reset();
        ae_th = 1;
        wr_left = 260;
        bus.burst_en_in = 1'b0;
        n = 0;
        while (pops < 260 && n < 1000) begin
            cycle();
            n++;
        end
        check("t6_pops", pops, 260);
        bus.burst_en_in = 1'b1;
        wait_idle("t6");
`ifdef FIFO_RD_POP_COUNT_EN
        exp_cnt = pops % 256;
`else
        exp_cnt = 0;
`endif
        check("t6_pop_count", int'(bus.pop_count_out), exp_cnt);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
